// File: rtl/k502_lbuf_ctrl.sv
// k502_lbuf_ctrl -- sprite line-buffer controller (ping-pong, two banks per word).
//
// Each line-buffer word is {bank1, bank0}, COL_W bits per bank. The display bank
// (OSEL) is read out to COL and cleared to TRANSP on write-back. The other bank is
// the draw bank, and the incoming sprite pixel is merged into it by priority.
// A 0->1 transition of H256 swaps the banks and starts a new line.
//
// Ports:
//   CLK, RESET (async, active-low), CEN (pixel-rate enable)
//   LD0              word strobe; LB_RD/SPAL/SPAL_VLD are sampled on accept
//   H256             line phase; a rising level swaps the banks
//   SPAL, SPAL_VLD   sprite pixel and its valid qualifier
//   LB_RD            line-buffer read word
//   LB_WR, LB_WE     write-back word and its strobe (one cycle after each accept)
//   OSEL, OCLR       display bank select and its complement
//   OLD              active-low bank-swap pulse
//   COL              {displayed pixel == TRANSP, displayed pixel}
//   COLL             sticky per-line collision flag
module k502_lbuf_ctrl #(
    parameter int               COL_W     = 4,
    parameter logic [COL_W-1:0] TRANSP    = {COL_W{1'b0}},
    parameter bit               PRIO_MODE = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CEN,
    input  logic                 LD0,
    input  logic                 H256,
    input  logic [COL_W-1:0]     SPAL,
    input  logic                 SPAL_VLD,
    input  logic [2*COL_W-1:0]   LB_RD,
    output logic [2*COL_W-1:0]   LB_WR,
    output logic                 LB_WE,
    output logic                 OSEL,
    output logic                 OCLR,
    output logic                 OLD,
    output logic [COL_W:0]       COL,
    output logic                 COLL
);

    // Merge the sprite pixel into the draw-bank pixel according to the priority mode.
    function automatic logic [COL_W-1:0] draw_pix(
        input logic [COL_W-1:0] w,
        input logic [COL_W-1:0] sp,
        input logic             op
    );
        logic [COL_W-1:0] r;
        if (PRIO_MODE) begin
            r = op ? sp : w;
        end else begin
            r = (op && (w == TRANSP)) ? sp : w;
        end
        return r;
    endfunction

    logic                 h256_q_r;
    logic                 bank_r;
    logic                 oclr_r;
    logic                 old_r;
    logic                 lb_we_r;
    logic                 coll_r;
    logic [COL_W:0]       col_r;
    logic [2*COL_W-1:0]   lb_wr_r;

    logic                 acc_s;
    logic                 swap_s;
    logic                 op_s;
    logic                 hit_s;
    logic [COL_W-1:0]     d_s;
    logic [COL_W-1:0]     w_s;
    logic [COL_W-1:0]     drawn_s;
    logic [2*COL_W-1:0]   wr_next_s;

    assign acc_s   = CEN & LD0;
    // The swap edge still processes its word with the old bank; bank_r changes after.
    assign swap_s  = acc_s & H256 & ~h256_q_r;
    assign op_s    = SPAL_VLD && (SPAL != TRANSP);
    assign hit_s   = op_s && (w_s != TRANSP);
    assign drawn_s = draw_pix(w_s, SPAL, op_s);

    // Split the read word into display and draw pixels and build the write-back word.
    always_comb begin
        d_s       = LB_RD[COL_W-1:0];
        w_s       = LB_RD[2*COL_W-1:COL_W];
        wr_next_s = {drawn_s, TRANSP};
        if (bank_r) begin
            d_s       = LB_RD[2*COL_W-1:COL_W];
            w_s       = LB_RD[COL_W-1:0];
            wr_next_s = {TRANSP, drawn_s};
        end else begin
            d_s       = LB_RD[COL_W-1:0];
            w_s       = LB_RD[2*COL_W-1:COL_W];
            wr_next_s = {drawn_s, TRANSP};
        end
    end

    // Bank state, swap pulse, datapath registers and collision flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            h256_q_r <= 1'b0;
            bank_r   <= 1'b0;
            oclr_r   <= 1'b1;
            old_r    <= 1'b1;
            lb_we_r  <= 1'b0;
            coll_r   <= 1'b0;
            col_r    <= {1'b1, TRANSP};
            lb_wr_r  <= {2*COL_W{1'b0}};
        end else begin
            // The write strobe lasts a single clock so one accept gives one RAM write.
            lb_we_r <= acc_s;
            if (CEN) begin
                old_r <= ~swap_s;
            end
            if (acc_s) begin
                h256_q_r <= H256;
                col_r    <= {(d_s == TRANSP), d_s};
                lb_wr_r  <= wr_next_s;
                if (swap_s) begin
                    bank_r <= ~bank_r;
                    oclr_r <= bank_r;
                    coll_r <= 1'b0;
                end else if (hit_s) begin
                    coll_r <= 1'b1;
                end
            end
        end
    end

    assign LB_WR = lb_wr_r;
    assign LB_WE = lb_we_r;
    assign OSEL  = bank_r;
    assign OCLR  = oclr_r;
    assign OLD   = old_r;
    assign COL   = col_r;
    assign COLL  = coll_r;

endmodule
